// File: rtl/robo_pkg.sv
// Shared definitions for the robot world emulator.
// Holds the orientation and cell codes, the FSM state type and two helper
// functions: the left-turn rotation and the per-cell debris removal cost.
package robo_pkg;

    // Orientation codes
    localparam logic [1:0] ORI_N = 2'b00;
    localparam logic [1:0] ORI_S = 2'b01;
    localparam logic [1:0] ORI_L = 2'b10;
    localparam logic [1:0] ORI_O = 2'b11;

    // Cell codes
    localparam logic [3:0] LIVRE  = 4'd0;
    localparam logic [3:0] PAREDE = 4'd1;
    localparam logic [3:0] PRETA  = 4'd2;
    localparam logic [3:0] LEVE   = 4'd3;
    localparam logic [3:0] MEDIO  = 4'd4;
    localparam logic [3:0] PESADO = 4'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ANOM = 2'd2
    } estado_t;

    // Left turn: N -> O -> S -> L -> N
    function automatic logic [1:0] gira_esq(input logic [1:0] ori);
        logic [1:0] r;
        case (ori)
            ORI_N:   r = ORI_O;
            ORI_O:   r = ORI_S;
            ORI_S:   r = ORI_L;
            default: r = ORI_N;
        endcase
        return r;
    endfunction

    // Full removal cost of a debris cell; zero for anything that is not debris
    function automatic logic [7:0] custo(input logic [3:0] cel,
                                         input logic [7:0] leve,
                                         input logic [7:0] medio,
                                         input logic [7:0] pesado);
        logic [7:0] r;
        case (cel)
            LEVE:    r = leve;
            MEDIO:   r = medio;
            PESADO:  r = pesado;
            default: r = 8'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/robo_sensores.sv
// Combinational neighbour lookup for the robot world.
// Inputs : lin/col/ori      current pose
//          cel_atual        map value under the robot
//          cel_frente       map value of the ahead cell (LIVRE when off-map)
//          cel_esq          map value of the left cell (LIVRE when off-map)
// Outputs: head/left/under/barrier sensors, and the ahead/left coordinates
//          with a validity flag so the top can address the map.
module robo_sensores
    import robo_pkg::*;
#(
    parameter int LINHAS  = 10,
    parameter int COLUNAS = 20,
    parameter int LW      = $clog2(LINHAS),
    parameter int CW      = $clog2(COLUNAS)
) (
    input  logic [LW-1:0] lin,
    input  logic [CW-1:0] col,
    input  logic [1:0]    ori,
    input  logic [3:0]    cel_atual,
    input  logic [3:0]    cel_frente,
    input  logic [3:0]    cel_esq,
    output logic          head,
    output logic          left,
    output logic          under,
    output logic          barrier,
    output logic          frente_ok,
    output logic [LW-1:0] frente_lin,
    output logic [CW-1:0] frente_col,
    output logic          esq_ok,
    output logic [LW-1:0] esq_lin,
    output logic [CW-1:0] esq_col
);

    localparam logic [LW-1:0] LIN_MAX = LW'(LINHAS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLUNAS - 1);
    localparam logic [LW-1:0] UM_L    = LW'(1);
    localparam logic [CW-1:0] UM_C    = CW'(1);

    logic pose_ok;

    // One cell in direction dir; ok is low when that step leaves the map
    function automatic void desloca(input  logic [1:0]    dir,
                                    input  logic [LW-1:0] l,
                                    input  logic [CW-1:0] c,
                                    output logic          ok,
                                    output logic [LW-1:0] nl,
                                    output logic [CW-1:0] nc);
        ok = 1'b1;
        nl = l;
        nc = c;
        case (dir)
            ORI_N: begin ok = (l != '0);      nl = l - UM_L; end
            ORI_S: begin ok = (l != LIN_MAX); nl = l + UM_L; end
            ORI_L: begin ok = (c != COL_MAX); nc = c + UM_C; end
            default: begin ok = (c != '0);    nc = c - UM_C; end
        endcase
    endfunction

    // The left neighbour is simply one step in the left-rotated direction
    always_comb begin
        logic ok_f;
        logic ok_e;
        ok_f       = 1'b0;
        ok_e       = 1'b0;
        frente_lin = lin;
        frente_col = col;
        esq_lin    = lin;
        esq_col    = col;
        pose_ok    = (lin <= LIN_MAX) && (col <= COL_MAX);
        desloca(ori, lin, col, ok_f, frente_lin, frente_col);
        desloca(gira_esq(ori), lin, col, ok_e, esq_lin, esq_col);
        frente_ok = pose_ok && ok_f;
        esq_ok    = pose_ok && ok_e;
    end

    assign head    = !frente_ok || (cel_frente == PAREDE);
    assign left    = !esq_ok    || (cel_esq == PAREDE);
    assign under   = pose_ok    && (cel_atual == PRETA);
    assign barrier = frente_ok  && (cel_frente >= LEVE);

endmodule

// File: rtl/robo_ambiente.sv
// Robot world emulator: cell map, robot pose and debris removal counter.
// Inputs : clock, reset (async, active-low); map_we/map_lin/map_col/map_wdata
//          map loading in IDLE; start/ini_lin/ini_col/ini_ori pose load;
//          mode_step/step single-stepping; anom_clr anomaly release;
//          avancar/girar/remover controller commands.
// Outputs: head/left/under/barrier sensors; linha/coluna/orient pose;
//          vida removal ticks left; removido clear pulse; anomalia; ticks.
module robo_ambiente
    import robo_pkg::*;
#(
    parameter int LINHAS      = 10,
    parameter int COLUNAS     = 20,
    parameter int VIDA_LEVE   = 3,
    parameter int VIDA_MEDIO  = 6,
    parameter int VIDA_PESADO = 9,
    parameter int LW          = $clog2(LINHAS),
    parameter int CW          = $clog2(COLUNAS),
    parameter int VW          = $clog2(VIDA_PESADO + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          map_we,
    input  logic [LW-1:0] map_lin,
    input  logic [CW-1:0] map_col,
    input  logic [3:0]    map_wdata,
    input  logic          start,
    input  logic [LW-1:0] ini_lin,
    input  logic [CW-1:0] ini_col,
    input  logic [1:0]    ini_ori,
    input  logic          mode_step,
    input  logic          step,
    input  logic          anom_clr,
    input  logic          avancar,
    input  logic          girar,
    input  logic          remover,
    output logic          head,
    output logic          left,
    output logic          under,
    output logic          barrier,
    output logic [LW-1:0] linha,
    output logic [CW-1:0] coluna,
    output logic [1:0]    orient,
    output logic [VW-1:0] vida,
    output logic          removido,
    output logic          anomalia,
    output logic [15:0]   ticks
);

    localparam logic [LW-1:0] LIN_MAX = LW'(LINHAS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLUNAS - 1);

    logic [3:0]    mapa_q [LINHAS][COLUNAS];
    logic [3:0]    mapa_d [LINHAS][COLUNAS];
    estado_t       estado_q, estado_d;
    logic [LW-1:0] lin_q, lin_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    ori_q, ori_d;
    logic [VW-1:0] vida_q, vida_d;
    logic          removido_q, removido_d;
    logic [15:0]   ticks_q, ticks_d;

    logic          frente_ok, esq_ok;
    logic [LW-1:0] frente_lin, esq_lin;
    logic [CW-1:0] frente_col, esq_col;
    logic [3:0]    cel_atual, cel_frente, cel_esq, cel_ini;
    logic [7:0]    custo_w;
    logic [VW-1:0] eff;
    logic          tick, ini_ok;

    // Map reads are gated by validity so off-map neighbours never index the array
    assign cel_atual  = (lin_q <= LIN_MAX && col_q <= COL_MAX) ? mapa_q[lin_q][col_q] : LIVRE;
    assign cel_frente = frente_ok ? mapa_q[frente_lin][frente_col] : LIVRE;
    assign cel_esq    = esq_ok    ? mapa_q[esq_lin][esq_col]       : LIVRE;

    robo_sensores #(
        .LINHAS (LINHAS),
        .COLUNAS(COLUNAS),
        .LW     (LW),
        .CW     (CW)
    ) u_sensores (
        .lin       (lin_q),
        .col       (col_q),
        .ori       (ori_q),
        .cel_atual (cel_atual),
        .cel_frente(cel_frente),
        .cel_esq   (cel_esq),
        .head      (head),
        .left      (left),
        .under     (under),
        .barrier   (barrier),
        .frente_ok (frente_ok),
        .frente_lin(frente_lin),
        .frente_col(frente_col),
        .esq_ok    (esq_ok),
        .esq_lin   (esq_lin),
        .esq_col   (esq_col)
    );

    // Next-state logic. In IDLE the map write is applied to mapa_d before the
    // start check so a coincident write is seen by it. In RUN the commands are
    // prioritised remove > advance > turn; a partial removal count (vida) is
    // kept only while the robot keeps removing the same debris.
    always_comb begin
        mapa_d     = mapa_q;
        estado_d   = estado_q;
        lin_d      = lin_q;
        col_d      = col_q;
        ori_d      = ori_q;
        vida_d     = vida_q;
        ticks_d    = ticks_q;
        removido_d = 1'b0;
        cel_ini    = LIVRE;
        ini_ok     = (ini_lin <= LIN_MAX) && (ini_col <= COL_MAX);
        tick       = mode_step ? step : 1'b1;
        custo_w    = custo(cel_frente, 8'(VIDA_LEVE), 8'(VIDA_MEDIO), 8'(VIDA_PESADO));
        eff        = (vida_q == '0) ? custo_w[VW-1:0] : vida_q;

        case (estado_q)
            IDLE: begin
                if (map_we && map_lin <= LIN_MAX && map_col <= COL_MAX)
                    mapa_d[map_lin][map_col] = map_wdata;
                if (start) begin
                    lin_d  = ini_lin;
                    col_d  = ini_col;
                    ori_d  = ini_ori;
                    vida_d = '0;
                    if (ini_ok)
                        cel_ini = mapa_d[ini_lin][ini_col];
                    if (!ini_ok || cel_ini == PAREDE || cel_ini >= LEVE)
                        estado_d = ANOM;
                    else
                        estado_d = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    if (ticks_q != 16'hFFFF)
                        ticks_d = ticks_q + 16'd1;
                    if (remover && barrier) begin
                        vida_d = eff - VW'(1);
                        if (eff == VW'(1)) begin
                            mapa_d[frente_lin][frente_col] = LIVRE;
                            removido_d = 1'b1;
                        end
                    end else if (avancar) begin
                        if (head || barrier) begin
                            estado_d = ANOM;
                        end else begin
                            lin_d  = frente_lin;
                            col_d  = frente_col;
                            vida_d = '0;
                        end
                    end else if (girar) begin
                        ori_d  = gira_esq(ori_q);
                        vida_d = '0;
                    end
                end
            end
            ANOM: begin
                if (anom_clr)
                    estado_d = IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

    // State registers, map included, all cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mapa_q     <= '{default: '{default: LIVRE}};
            estado_q   <= IDLE;
            lin_q      <= '0;
            col_q      <= '0;
            ori_q      <= ORI_N;
            vida_q     <= '0;
            removido_q <= 1'b0;
            ticks_q    <= '0;
        end else begin
            mapa_q     <= mapa_d;
            estado_q   <= estado_d;
            lin_q      <= lin_d;
            col_q      <= col_d;
            ori_q      <= ori_d;
            vida_q     <= vida_d;
            removido_q <= removido_d;
            ticks_q    <= ticks_d;
        end
    end

    assign linha    = lin_q;
    assign coluna   = col_q;
    assign orient   = ori_q;
    assign vida     = vida_q;
    assign removido = removido_q;
    assign anomalia = (estado_q == ANOM);
    assign ticks    = ticks_q;

endmodule

// File: tb/tb_robo_ambiente.sv
// Directed self-checking bench for robo_ambiente (10x20 map, costs 3/6/9).
module tb_robo_ambiente;

    localparam int LW = 4;
    localparam int CW = 5;
    localparam int VW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          map_we = 1'b0;
    logic [LW-1:0] map_lin = '0;
    logic [CW-1:0] map_col = '0;
    logic [3:0]    map_wdata = '0;
    logic          start = 1'b0;
    logic [LW-1:0] ini_lin = '0;
    logic [CW-1:0] ini_col = '0;
    logic [1:0]    ini_ori = '0;
    logic          mode_step = 1'b0;
    logic          step = 1'b0;
    logic          anom_clr = 1'b0;
    logic          avancar = 1'b0;
    logic          girar = 1'b0;
    logic          remover = 1'b0;
    logic          head, left, under, barrier;
    logic [LW-1:0] linha;
    logic [CW-1:0] coluna;
    logic [1:0]    orient;
    logic [VW-1:0] vida;
    logic          removido, anomalia;
    logic [15:0]   ticks;

    int checks = 0;
    int errors = 0;

    robo_ambiente #(
        .LINHAS(10), .COLUNAS(20), .VIDA_LEVE(3), .VIDA_MEDIO(6), .VIDA_PESADO(9)
    ) dut (
        .clock(clock), .reset(reset),
        .map_we(map_we), .map_lin(map_lin), .map_col(map_col), .map_wdata(map_wdata),
        .start(start), .ini_lin(ini_lin), .ini_col(ini_col), .ini_ori(ini_ori),
        .mode_step(mode_step), .step(step), .anom_clr(anom_clr),
        .avancar(avancar), .girar(girar), .remover(remover),
        .head(head), .left(left), .under(under), .barrier(barrier),
        .linha(linha), .coluna(coluna), .orient(orient), .vida(vida),
        .removido(removido), .anomalia(anomalia), .ticks(ticks)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic cycle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        map_we = 1'b0; start = 1'b0; mode_step = 1'b0; step = 1'b0;
        anom_clr = 1'b0; avancar = 1'b0; girar = 1'b0; remover = 1'b0;
        cycle(1);
        reset = 1'b1;
    endtask

    task automatic write_cell(input logic [LW-1:0] l, input logic [CW-1:0] c, input logic [3:0] v);
        map_we = 1'b1; map_lin = l; map_col = c; map_wdata = v;
        cycle(1);
        map_we = 1'b0;
    endtask

    task automatic do_start(input logic [LW-1:0] l, input logic [CW-1:0] c, input logic [1:0] o);
        start = 1'b1; ini_lin = l; ini_col = c; ini_ori = o;
        cycle(1);
        start = 1'b0;
    endtask

    task automatic clear_anom();
        anom_clr = 1'b1;
        cycle(1);
        anom_clr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (linha !== 4'd0)     begin errors++; $display("[TB] FAIL reset_linha got %0d want 0", linha); end
        if (coluna !== 5'd0)    begin errors++; $display("[TB] FAIL reset_coluna got %0d want 0", coluna); end
        if (orient !== 2'b00)   begin errors++; $display("[TB] FAIL reset_orient got %0d want 0", orient); end
        if (vida !== 4'd0)      begin errors++; $display("[TB] FAIL reset_vida got %0d want 0", vida); end
        if (removido !== 1'b0)  begin errors++; $display("[TB] FAIL reset_removido got %0b want 0", removido); end
        if (anomalia !== 1'b0)  begin errors++; $display("[TB] FAIL reset_anomalia got %0b want 0", anomalia); end
        if (ticks !== 16'd0)    begin errors++; $display("[TB] FAIL reset_ticks got %0d want 0", ticks); end
    endtask

    task automatic test_avanco();
        logic [LW-1:0] exp_l;
        do_reset();
        do_start(4'd5, 5'd5, 2'b00);
        checks++;
        if (linha !== 4'd5) begin errors++; $display("[TB] FAIL avanco_inicio got %0d want 5", linha); end
        avancar = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cycle(1);
            exp_l = LW'(5 - i);
            checks++;
            if (linha !== exp_l) begin errors++; $display("[TB] FAIL avanco_linha%0d got %0d want %0d", i, linha, exp_l); end
        end
        checks++;
        if (head !== 1'b1) begin errors++; $display("[TB] FAIL avanco_head_borda got %0b want 1", head); end
        cycle(1);
        checks += 3;
        if (anomalia !== 1'b1) begin errors++; $display("[TB] FAIL avanco_anomalia got %0b want 1", anomalia); end
        if (linha !== 4'd0)    begin errors++; $display("[TB] FAIL avanco_linha_anom got %0d want 0", linha); end
        if (ticks !== 16'd6)   begin errors++; $display("[TB] FAIL avanco_ticks got %0d want 6", ticks); end
        avancar = 1'b0;
        clear_anom();
        checks++;
        if (anomalia !== 1'b0) begin errors++; $display("[TB] FAIL avanco_clr got %0b want 0", anomalia); end
    endtask

    task automatic test_remocao_leve();
        logic [VW-1:0] exp_v [3];
        exp_v = '{4'd2, 4'd1, 4'd0};
        do_reset();
        write_cell(4'd4, 5'd5, 4'd3);
        do_start(4'd5, 5'd5, 2'b00);
        checks += 2;
        if (barrier !== 1'b1) begin errors++; $display("[TB] FAIL leve_barrier got %0b want 1", barrier); end
        if (head !== 1'b0)    begin errors++; $display("[TB] FAIL leve_head got %0b want 0", head); end
        remover = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1);
            checks++;
            if (vida !== exp_v[i]) begin errors++; $display("[TB] FAIL leve_vida%0d got %0d want %0d", i, vida, exp_v[i]); end
            if (i < 2) begin
                checks++;
                if (removido !== 1'b0) begin errors++; $display("[TB] FAIL leve_removido_cedo%0d got %0b want 0", i, removido); end
            end
        end
        checks += 2;
        if (removido !== 1'b1) begin errors++; $display("[TB] FAIL leve_removido got %0b want 1", removido); end
        if (barrier !== 1'b0)  begin errors++; $display("[TB] FAIL leve_barrier_limpo got %0b want 0", barrier); end
        cycle(1);
        checks += 2;
        if (removido !== 1'b0) begin errors++; $display("[TB] FAIL leve_pulso got %0b want 0", removido); end
        if (linha !== 4'd5)    begin errors++; $display("[TB] FAIL leve_pose got %0d want 5", linha); end
        remover = 1'b0;
    endtask

    task automatic test_abandono();
        do_reset();
        write_cell(4'd4, 5'd5, 4'd5);
        do_start(4'd5, 5'd5, 2'b00);
        remover = 1'b1;
        cycle(4);
        checks++;
        if (vida !== 4'd5) begin errors++; $display("[TB] FAIL abandono_vida_parcial got %0d want 5", vida); end
        remover = 1'b0;
        girar = 1'b1;
        cycle(1);
        checks++;
        if (orient !== 2'b11) begin errors++; $display("[TB] FAIL abandono_giro1 got %0d want 3", orient); end
        cycle(3);
        checks += 2;
        if (vida !== 4'd0)    begin errors++; $display("[TB] FAIL abandono_vida_giros got %0d want 0", vida); end
        if (orient !== 2'b00) begin errors++; $display("[TB] FAIL abandono_orient got %0d want 0", orient); end
        girar = 1'b0;
        remover = 1'b1;
        cycle(1);
        checks++;
        if (vida !== 4'd8) begin errors++; $display("[TB] FAIL abandono_recarga got %0d want 8", vida); end
        remover = 1'b0;
    endtask

    task automatic test_reset_meio();
        do_reset();
        write_cell(4'd4, 5'd5, 4'd5);
        do_start(4'd5, 5'd5, 2'b10);
        girar = 1'b1;
        cycle(1);
        girar = 1'b0;
        remover = 1'b1;
        cycle(5);
        checks++;
        if (vida !== 4'd4) begin errors++; $display("[TB] FAIL meio_vida got %0d want 4", vida); end
        #2 reset = 1'b0;
        #2;
        checks += 7;
        if (linha !== 4'd0)    begin errors++; $display("[TB] FAIL meio_linha got %0d want 0", linha); end
        if (coluna !== 5'd0)   begin errors++; $display("[TB] FAIL meio_coluna got %0d want 0", coluna); end
        if (orient !== 2'b00)  begin errors++; $display("[TB] FAIL meio_orient got %0d want 0", orient); end
        if (vida !== 4'd0)     begin errors++; $display("[TB] FAIL meio_vida_reset got %0d want 0", vida); end
        if (removido !== 1'b0) begin errors++; $display("[TB] FAIL meio_removido got %0b want 0", removido); end
        if (anomalia !== 1'b0) begin errors++; $display("[TB] FAIL meio_anomalia got %0b want 0", anomalia); end
        if (ticks !== 16'd0)   begin errors++; $display("[TB] FAIL meio_ticks got %0d want 0", ticks); end
        remover = 1'b0;
        cycle(1);
        reset = 1'b1;
        do_start(4'd5, 5'd5, 2'b00);
        checks += 2;
        if (barrier !== 1'b0)  begin errors++; $display("[TB] FAIL meio_mapa_limpo got %0b want 0", barrier); end
        if (anomalia !== 1'b0) begin errors++; $display("[TB] FAIL meio_run got %0b want 0", anomalia); end
    endtask

    task automatic test_step();
        do_reset();
        mode_step = 1'b1;
        do_start(4'd5, 5'd5, 2'b00);
        avancar = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step = (i == 3 || i == 9 || i == 15);
            cycle(1);
            if (i == 10) begin
                checks++;
                if (linha !== 4'd3) begin errors++; $display("[TB] FAIL step_meio got %0d want 3", linha); end
            end
        end
        step = 1'b0;
        checks += 2;
        if (linha !== 4'd2)  begin errors++; $display("[TB] FAIL step_linha got %0d want 2", linha); end
        if (ticks !== 16'd3) begin errors++; $display("[TB] FAIL step_ticks got %0d want 3", ticks); end
        avancar = 1'b0;
        mode_step = 1'b0;
    endtask

    task automatic test_partida_parede();
        do_reset();
        write_cell(4'd5, 5'd5, 4'd1);
        do_start(4'd5, 5'd5, 2'b10);
        checks += 3;
        if (anomalia !== 1'b1) begin errors++; $display("[TB] FAIL parede_anom got %0b want 1", anomalia); end
        if (linha !== 4'd5)    begin errors++; $display("[TB] FAIL parede_pose got %0d want 5", linha); end
        if (orient !== 2'b10)  begin errors++; $display("[TB] FAIL parede_orient got %0d want 2", orient); end
        avancar = 1'b1;
        cycle(2);
        avancar = 1'b0;
        checks += 2;
        if (ticks !== 16'd0) begin errors++; $display("[TB] FAIL parede_congelado got %0d want 0", ticks); end
        if (coluna !== 5'd5) begin errors++; $display("[TB] FAIL parede_coluna got %0d want 5", coluna); end
        clear_anom();
        checks++;
        if (anomalia !== 1'b0) begin errors++; $display("[TB] FAIL parede_clr got %0b want 0", anomalia); end
        write_cell(4'd5, 5'd5, 4'd0);
        do_start(4'd5, 5'd5, 2'b00);
        checks++;
        if (anomalia !== 1'b0) begin errors++; $display("[TB] FAIL parede_run got %0b want 0", anomalia); end
        cycle(1);
        checks++;
        if (ticks !== 16'd1) begin errors++; $display("[TB] FAIL parede_ticks_run got %0d want 1", ticks); end
    endtask

    task automatic test_limites();
        do_reset();
        write_cell(4'd2, 5'd2, 4'd2);
        do_start(4'd2, 5'd2, 2'b00);
        checks++;
        if (under !== 1'b1) begin errors++; $display("[TB] FAIL lim_under got %0b want 1", under); end
        do_reset();
        do_start(4'd10, 5'd3, 2'b00);
        checks++;
        if (anomalia !== 1'b1) begin errors++; $display("[TB] FAIL lim_fora got %0b want 1", anomalia); end
        clear_anom();
        map_we = 1'b1; map_lin = 4'd3; map_col = 5'd3; map_wdata = 4'd4;
        do_start(4'd3, 5'd3, 2'b00);
        map_we = 1'b0;
        checks++;
        if (anomalia !== 1'b1) begin errors++; $display("[TB] FAIL lim_escrita_partida got %0b want 1", anomalia); end
        clear_anom();
        do_start(4'd5, 5'd0, 2'b00);
        checks += 3;
        if (anomalia !== 1'b0) begin errors++; $display("[TB] FAIL lim_run got %0b want 0", anomalia); end
        if (left !== 1'b1)     begin errors++; $display("[TB] FAIL lim_left_borda got %0b want 1", left); end
        if (head !== 1'b0)     begin errors++; $display("[TB] FAIL lim_head_livre got %0b want 0", head); end
        girar = 1'b1;
        cycle(1);
        girar = 1'b0;
        checks += 3;
        if (orient !== 2'b11) begin errors++; $display("[TB] FAIL lim_orient got %0d want 3", orient); end
        if (head !== 1'b1)    begin errors++; $display("[TB] FAIL lim_head_borda got %0b want 1", head); end
        if (left !== 1'b0)    begin errors++; $display("[TB] FAIL lim_left_livre got %0b want 0", left); end
    endtask

    initial begin
        test_reset();
        test_avanco();
        test_remocao_leve();
        test_abandono();
        test_reset_meio();
        test_step();
        test_partida_parede();
        test_limites();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/robo_ambiente.md
Name: robo_ambiente

Overview:
- Synthesizable, parametrised emulator of the robot's world.
- Holds the cell map, the robot pose and the debris-removal counter.
- Derives the head/left/under/barrier sensors for the Robo controller and applies its avancar/girar/recolher_entulho commands each tick.
- Replaces the behavioural map handling with hardware usable on the FPGA board, with step mode and anomaly latching.

Parameters:
LINHAS, 10, map rows
COLUNAS, 20, map columns
VIDA_LEVE, 3, removal ticks for light debris (cell 3)
VIDA_MEDIO, 6, removal ticks for medium debris (cell 4)
VIDA_PESADO, 9, removal ticks for heavy debris (cell 5)
Derived: LW=$clog2(LINHAS), CW=$clog2(COLUNAS), VW=$clog2(VIDA_PESADO+1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low
map_we  in  1  map write strobe (IDLE only)
map_lin  in  LW  write row
map_col  in  CW  write column
map_wdata  in  4  cell code: 0 free, 1 wall, 2 black, 3/4/5 debris
start  in  1  pulse: load pose and enter RUN
ini_lin  in  LW  start row
ini_col  in  CW  start column
ini_ori  in  2  start orientation: N=00, S=01, L=10, O=11
mode_step  in  1  1 = step mode, 0 = continuous
step  in  1  single-cycle step pulse
anom_clr  in  1  leave ANOM and return to IDLE
avancar  in  1  controller command: move forward
girar  in  1  controller command: turn left
remover  in  1  controller command: remove debris ahead
head  out  1  wall or map edge ahead
left  out  1  wall or map edge on the left
under  out  1  current cell is 2
barrier  out  1  debris (>=3) ahead; 0 at the map edge
linha  out  LW  robot row
coluna  out  CW  robot column
orient  out  2  robot orientation
vida  out  VW  remaining removal ticks
removido  out  1  one-cycle pulse when debris is cleared
anomalia  out  1  high while in ANOM
ticks  out  16  applied ticks, saturating at 16'hFFFF

Behaviour:
- Reset (async, reset=0):
  - Every map cell is 0; state is IDLE.
  - linha=0, coluna=0, orient=N, vida=0, removido=0, anomalia=0, ticks=0.
- FSM states: IDLE, RUN, ANOM.
- IDLE:
  - map_we writes map[map_lin][map_col] at the clock edge. Out-of-range addresses are ignored.
  - start, with ini_lin>=LINHAS, ini_col>=COLUNAS, or start cell ==1 or >=3 -> ANOM. The pose is still loaded.
  - Otherwise start -> RUN with the pose loaded and vida=0.
  - If start and map_we coincide, the write happens first; the start check sees the new cell.
- RUN:
  - map_we and start are ignored.
  - tick = mode_step ? step : 1. No state changes without a tick.
  - Ahead cell by orientation: N (lin-1,col), S (lin+1,col), L (lin,col+1), O (lin,col-1).
  - Left cell by orientation: N (lin,col-1), S (lin,col+1), L (lin-1,col), O (lin+1,col).
  - Sensors are combinational from the current registers and map. They are valid in the same cycle as the pose.
- Per tick, first match wins:
  - a) remover=1 and barrier=1:
    - eff = (vida==0) ? cost(ahead) : vida; vida <= eff-1.
    - If eff-1==0: the ahead cell <= 0 and removido pulses for 1 cycle.
    - Pose is unchanged.
  - b) avancar=1:
    - If head or barrier -> ANOM, pose unchanged.
    - Otherwise step one cell and set vida <= 0.
  - c) girar=1: turn left (N->O->S->L->N) and set vida <= 0.
  - d) Otherwise nothing changes. Any remover without barrier falls through to b/c.
  - ticks increments on every tick in RUN.
- Abandoning debris (move or turn) discards partial progress. Returning to that debris reloads the full cost.
- ANOM:
  - anomalia=1; all registers and the map are frozen.
  - anom_clr -> IDLE with the map retained.
- mode_step may toggle at any time and takes effect on the next cycle.
- A step pulse in continuous mode is ignored.

Decomposition:
- Shared package robo_pkg holds:
  - Orientation codes N/S/L/O.
  - Cell codes LIVRE=0, PAREDE=1, PRETA=2, LEVE=3, MEDIO=4, PESADO=5.
  - FSM state typedef.
  - Functions gira_esq(ori) and custo(cell, leve, medio, pesado).
- Sub-module robo_sensores: combinational neighbour lookup. Input is the pose plus the map read of the current, ahead and left cells; outputs are head, left, under, barrier and the ahead coordinates.

Test Plan:
- 10x20 all-free map, start (5,5,N), continuous mode, avancar held -> linha 4,3,2,1,0 on successive ticks. The next tick (head=1) -> anomalia=1, linha=0.
- Cell (4,5)=3, start (5,5,N), remover held -> barrier=1, vida 2,1,0. removido pulses on the 3rd tick, map[4][5]=0, barrier=0.
- Cell (4,5)=5, remover for 4 ticks, then girar, girar, girar, girar, then remover -> vida=5 before the turns, vida=0 after them, vida=8 after the final remover (full reload).
- mode_step=1, avancar held, 3 step pulses spread over 20 cycles -> exactly 3 moves, ticks=3.
- start at a wall cell -> ANOM immediately. Then anom_clr -> IDLE, fix the cell via map_we, start again -> RUN.
- Reset asserted mid-removal (vida=4) -> all outputs reach their reset values with no clock edge, and the map is cleared to 0.
